vga_box_renderer: RTL



---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_box_renderer_if.sv | 27 ++
 rtl/vga_box_motion.sv | 55 +++++
 rtl/vga_box_renderer.sv | 113 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel/coordinate types and the per-axis bounce rule
// used by the box renderer.
package vga_pkg;

    localparam int H_DISP  = 640;
    localparam int V_DISP  = 480;
    localparam int H_FRAME = 800;
    localparam int V_FRAME = 525;
    localparam int COORD_W = 11;

    typedef logic [11:0]        rgb12_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t pos;
        logic   dir;    // 1 = increasing coordinate
    } axis_t;

    // One motion step on one axis; sums are one bit wider so they cannot wrap.
    function automatic axis_t axis_next(
        input axis_t              cur,
        input logic [COORD_W:0]   limit,
        input logic [COORD_W:0]   size,
        input logic [COORD_W:0]   step
    );
        axis_t            nxt;
        logic [COORD_W:0] far_edge;
        far_edge = {1'b0, cur.pos} + size + step;
        nxt      = cur;
        if (cur.dir) begin
            if (far_edge > limit) begin
                nxt.pos = COORD_W'(limit - size);
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = COORD_W'({1'b0, cur.pos} + step);
                nxt.dir = 1'b1;
            end
        end else begin
            if ({1'b0, cur.pos} < step) begin
                nxt.pos = '0;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = COORD_W'({1'b0, cur.pos} - step);
                nxt.dir = 1'b0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_box_renderer_if.sv
// Timing-controller-side inputs and VGA-pin outputs of the box renderer.
interface vga_box_renderer_if;
    import vga_pkg::*;

    logic       hsync_i;
    logic       vsync_i;
    logic       disp_active_i;
    coord_t     xcol_i;
    coord_t     yrow_i;
    logic       pause_i;
    logic [3:0] red_o;
    logic [3:0] green_o;
    logic [3:0] blue_o;
    logic       hsync_o;
    logic       vsync_o;
    logic       frame_tick_o;

    modport slave (
        input  hsync_i, vsync_i, disp_active_i, xcol_i, yrow_i, pause_i,
        output red_o, green_o, blue_o, hsync_o, vsync_o, frame_tick_o
    );

    modport master (
        output hsync_i, vsync_i, disp_active_i, xcol_i, yrow_i, pause_i,
        input  red_o, green_o, blue_o, hsync_o, vsync_o, frame_tick_o
    );
endinterface

// File: rtl/vga_box_motion.sv
// Box position/direction state; moves once per frame at the update strobe,
// bouncing off the active-region edges.
module vga_box_motion #(
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_update,
    input  logic            i_pause,
    output vga_pkg::coord_t o_box_x,
    output vga_pkg::coord_t o_box_y,
    output logic            o_frame_tick
);
    import vga_pkg::*;

    localparam logic [COORD_W:0] LIM_X  = 12'(H_DISP);
    localparam logic [COORD_W:0] LIM_Y  = 12'(V_DISP);
    localparam logic [COORD_W:0] SIZE_W = 12'(BOX_SIZE);
    localparam logic [COORD_W:0] STEP_W = 12'(STEP);

    axis_t r_ax_x;
    axis_t r_ax_y;
    axis_t w_nx_x;
    axis_t w_nx_y;
    logic  r_tick;

    // Candidate next position for both axes, evaluated independently
    always_comb begin
        w_nx_x = axis_next(r_ax_x, LIM_X, SIZE_W, STEP_W);
        w_nx_y = axis_next(r_ax_y, LIM_Y, SIZE_W, STEP_W);
    end

    // Position state; an update point during reset is simply lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ax_x <= '{pos: 11'd0, dir: 1'b1};
            r_ax_y <= '{pos: 11'd0, dir: 1'b1};
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_update;
            if (i_update && !i_pause) begin
                r_ax_x <= w_nx_x;
                r_ax_y <= w_nx_y;
            end
        end
    end

    assign o_box_x      = r_ax_x.pos;
    assign o_box_y      = r_ax_y.pos;
    assign o_frame_tick = r_tick;

endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline: box hit-test and checker phase, then colour
// select with blanking; syncs ride the same two stages.
module vga_box_renderer #(
    parameter int          H_DISP   = 640,
    parameter int          V_DISP   = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [11:0] BOX_RGB  = 12'hF80,
    parameter logic [11:0] BG_A_RGB = 12'h222,
    parameter logic [11:0] BG_B_RGB = 12'h444
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    vga_box_renderer_if.slave  bus
);
    import vga_pkg::*;

    coord_t w_box_x;
    coord_t w_box_y;
    logic   w_update;
    logic   w_frame_tick;
    logic   w_in_box;
    logic   w_checker;
    rgb12_t w_rgb;

    logic   r_s1_hsync;
    logic   r_s1_vsync;
    logic   r_s1_active;
    logic   r_s1_in_box;
    logic   r_s1_checker;
    rgb12_t r_rgb;
    logic   r_hsync;
    logic   r_vsync;

    // First column of the first vertical-blanking line
    assign w_update = (bus.xcol_i == 11'd0) && (bus.yrow_i == 11'(V_DISP));

    vga_box_motion #(
        .H_DISP   (H_DISP),
        .V_DISP   (V_DISP),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_motion (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_update     (w_update),
        .i_pause      (bus.pause_i),
        .o_box_x      (w_box_x),
        .o_box_y      (w_box_y),
        .o_frame_tick (w_frame_tick)
    );

    // Box hit-test and 32-pixel checker phase of the incoming pixel
    always_comb begin
        w_in_box  = ({1'b0, bus.xcol_i} >= {1'b0, w_box_x}) &&
                    ({1'b0, bus.xcol_i} <  ({1'b0, w_box_x} + 12'(BOX_SIZE))) &&
                    ({1'b0, bus.yrow_i} >= {1'b0, w_box_y}) &&
                    ({1'b0, bus.yrow_i} <  ({1'b0, w_box_y} + 12'(BOX_SIZE)));
        w_checker = bus.xcol_i[5] ^ bus.yrow_i[5];
    end

    // Stage 1 register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
            r_s1_active  <= 1'b0;
            r_s1_in_box  <= 1'b0;
            r_s1_checker <= 1'b0;
        end else begin
            r_s1_hsync   <= bus.hsync_i;
            r_s1_vsync   <= bus.vsync_i;
            r_s1_active  <= bus.disp_active_i;
            r_s1_in_box  <= w_in_box;
            r_s1_checker <= w_checker;
        end
    end

    // Colour select; blanking has priority over everything
    always_comb begin
        w_rgb = 12'h000;
        if (!r_s1_active) begin
            w_rgb = 12'h000;
        end else if (r_s1_in_box) begin
            w_rgb = BOX_RGB;
        end else if (r_s1_checker) begin
            w_rgb = BG_B_RGB;
        end else begin
            w_rgb = BG_A_RGB;
        end
    end

    // Stage 2 register driving the pins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb;
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
        end
    end

    assign bus.red_o        = r_rgb[11:8];
    assign bus.green_o      = r_rgb[7:4];
    assign bus.blue_o       = r_rgb[3:0];
    assign bus.hsync_o      = r_hsync;
    assign bus.vsync_o      = r_vsync;
    assign bus.frame_tick_o = w_frame_tick;

endmodule
